// File: rtl/regex_cpu.sv
// regex_cpu -- single-thread regex engine core.
//
// Takes one (pc, cc_id) thread and fetches its instruction from the shared code
// memory. It executes the instruction against the selected character of the
// current window. The result is 0..2 successor threads, or an accept pulse.
//
// Optional feature macro: REGEX_CPU_MATCH_ANY_EN
//   defined   : opcode 101 (MATCH_ANY) emits (pc+1, cc_id+1) when the char != 0
//   undefined : opcode 101 behaves exactly like END_WITHOUT_ACCEPTING
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   current_characters  character window, char k = bits [k*CW +: CW]
//   input_pc_valid/_ready, input_cc_id, input_pc   thread intake (ready only when idle)
//   memory_valid/_ready, memory_addr, memory_data  instruction fetch, data one cycle after grant
//   output_pc_valid/_ready, output_pc, output_cc_id successor thread handshake
//   accepts             one-cycle match pulse
module regex_cpu #(
  parameter int PC_WIDTH          = 8,
  parameter int CC_ID_BITS        = 1,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]    current_characters,
  input  logic                                          input_pc_valid,
  input  logic [CC_ID_BITS-1:0]                         input_cc_id,
  input  logic [PC_WIDTH-1:0]                           input_pc,
  output logic                                          input_pc_ready,
  input  logic                                          memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                       memory_data,
  output logic                                          memory_valid,
  output logic [CC_ID_BITS-1:0]                         output_cc_id,
  output logic                                          output_pc_valid,
  output logic [PC_WIDTH-1:0]                           output_pc,
  input  logic                                          output_pc_ready,
  output logic                                          accepts
);

  localparam int NCHARS = 2**CC_ID_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_DATA, S_EXEC, S_OUT1, S_OUT2
  } state_t;

  typedef enum logic [2:0] {
    OP_ACCEPT         = 3'b000,
    OP_SPLIT          = 3'b001,
    OP_MATCH_CHAR     = 3'b010,
    OP_JMP            = 3'b011,
    OP_END            = 3'b100,
    OP_MATCH_ANY      = 3'b101,
    OP_ACCEPT_PARTIAL = 3'b110,
    OP_NOT_MATCH_CHAR = 3'b111
  } opcode_t;

  state_t                    state, state_next;
  logic [PC_WIDTH-1:0]       pc_r;
  logic [CC_ID_BITS-1:0]     cc_r;
  logic [MEMORY_WIDTH-1:0]   instr_r;
  logic [PC_WIDTH-1:0]       out_pc_r;
  logic [CC_ID_BITS-1:0]     out_cc_r;

  logic [CHARACTER_WIDTH-1:0] chars [NCHARS];
  logic [CHARACTER_WIDTH-1:0] c;
  opcode_t                    opcode;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic [CC_ID_BITS-1:0]      cc_inc;
  logic [PC_WIDTH-1:0]        target_pc;
  logic [CHARACTER_WIDTH-1:0] lit_char;
  logic                       exec_emit;
  logic                       exec_split;
  logic                       exec_accept;
  logic [PC_WIDTH-1:0]        exec_pc;
  logic [CC_ID_BITS-1:0]      exec_cc;
  logic                       unused_instr_bits;

  always_comb begin
    for (int k = 0; k < NCHARS; k++) begin
      chars[k] = current_characters[k*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    end
  end

  assign c         = chars[cc_r];
  assign opcode    = opcode_t'(instr_r[MEMORY_WIDTH-1 -: 3]);
  assign target_pc = instr_r[PC_WIDTH-1:0];
  assign lit_char  = instr_r[CHARACTER_WIDTH-1:0];
  assign pc_inc    = pc_r + PC_WIDTH'(1);
  assign cc_inc    = cc_r + CC_ID_BITS'(1);
  // Payload bits above the pc/char fields are don't-care for every opcode.
  assign unused_instr_bits = ^instr_r;

  // Instruction decode: what the EXEC cycle does with the thread.
  always_comb begin
    exec_emit   = 1'b0;
    exec_split  = 1'b0;
    exec_accept = 1'b0;
    exec_pc     = pc_inc;
    exec_cc     = cc_r;
    unique case (opcode)
      OP_ACCEPT:         exec_accept = (c == '0);
      OP_SPLIT:          begin exec_emit = 1'b1; exec_split = 1'b1; end
      OP_MATCH_CHAR:     begin exec_emit = (c == lit_char); exec_cc = cc_inc; end
      OP_JMP:            begin exec_emit = 1'b1; exec_pc = target_pc; end
      OP_END:            exec_emit = 1'b0;
`ifdef REGEX_CPU_MATCH_ANY_EN
      OP_MATCH_ANY:      begin exec_emit = (c != '0); exec_cc = cc_inc; end
`else
      OP_MATCH_ANY:      exec_emit = 1'b0;
`endif
      OP_ACCEPT_PARTIAL: exec_accept = 1'b1;
      OP_NOT_MATCH_CHAR: begin exec_emit = (c != lit_char); exec_cc = cc_inc; end
      default:           exec_emit = 1'b0;
    endcase
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next      = state;
    input_pc_ready  = 1'b0;
    memory_valid    = 1'b0;
    output_pc_valid = 1'b0;
    accepts         = 1'b0;
    unique case (state)
      S_IDLE: begin
        input_pc_ready = 1'b1;
        if (input_pc_valid) state_next = S_FETCH;
      end
      S_FETCH: begin
        memory_valid = 1'b1;
        if (memory_ready) state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: state_next = S_EXEC;
      S_EXEC: begin
        accepts = exec_accept;
        if (!exec_emit)     state_next = S_IDLE;
        else if (exec_split) state_next = S_OUT1;
        else                 state_next = S_OUT2;
      end
      S_OUT1: begin
        output_pc_valid = 1'b1;
        if (output_pc_ready) state_next = S_OUT2;
      end
      S_OUT2: begin
        output_pc_valid = 1'b1;
        if (output_pc_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign memory_addr  = MEMORY_ADDR_WIDTH'(pc_r);
  assign output_pc    = out_pc_r;
  assign output_cc_id = out_cc_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc_r     <= '0;
      cc_r     <= '0;
      instr_r  <= '0;
      out_pc_r <= '0;
      out_cc_r <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && input_pc_valid) begin
        pc_r <= input_pc;
        cc_r <= input_cc_id;
      end
      if (state == S_WAIT_DATA) instr_r <= memory_data;
      if (state == S_EXEC) begin
        out_pc_r <= exec_pc;
        out_cc_r <= exec_cc;
      end
      // Second half of a SPLIT: swap in the branch target once pc+1 is taken.
      if (state == S_OUT1 && output_pc_ready) out_pc_r <= target_pc;
    end
  end

endmodule

// File: tb/tb_regex_cpu.sv
// Directed testbench for regex_cpu: table of single-thread vectors plus
// hand-written sequences for the END sweep and mid-fetch reset.
module tb_regex_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] current_characters;
  logic        input_pc_valid;
  logic [0:0]  input_cc_id;
  logic [7:0]  input_pc;
  logic        input_pc_ready;
  logic        memory_ready;
  logic [10:0] memory_addr;
  logic [15:0] memory_data;
  logic        memory_valid;
  logic [0:0]  output_cc_id;
  logic        output_pc_valid;
  logic [7:0]  output_pc;
  logic        output_pc_ready;
  logic        accepts;

  regex_cpu dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters),
    .input_pc_valid(input_pc_valid), .input_cc_id(input_cc_id),
    .input_pc(input_pc), .input_pc_ready(input_pc_ready),
    .memory_ready(memory_ready), .memory_addr(memory_addr),
    .memory_data(memory_data), .memory_valid(memory_valid),
    .output_cc_id(output_cc_id), .output_pc_valid(output_pc_valid),
    .output_pc(output_pc), .output_pc_ready(output_pc_ready),
    .accepts(accepts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic        cc;
    logic [15:0] instr;
    logic [15:0] chars;
    int          nout;
    logic [7:0]  p0;
    logic        c0;
    logic [7:0]  p1;
    logic        c1;
    logic        acc;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  vec_t vec [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [7:0] got_pc [2];
    logic       got_cc [2];
    logic [7:0] seen_pc;
    logic       seen_cc;
    int n, extra_acc;
    bit hold, done;
    nvec++;
    current_characters = v.chars;
    input_pc       = v.pc;
    input_cc_id    = v.cc;
    input_pc_valid = 1'b1;
    chk({name, " in_ready"}, 32'(input_pc_ready), 32'd1);
    tick();
    input_pc_valid = 1'b0;
    chk({name, " mem_valid fetch"}, 32'(memory_valid), 32'd1);
    chk({name, " mem_addr"}, 32'(memory_addr), 32'(v.pc));
    tick();
    chk({name, " mem_valid stall"}, 32'(memory_valid), 32'd1);
    chk({name, " mem_addr stall"}, 32'(memory_addr), 32'(v.pc));
    memory_ready = 1'b1;
    tick();
    memory_ready = 1'b0;
    memory_data  = v.instr;
    chk({name, " mem_valid wait"}, 32'(memory_valid), 32'd0);
    tick();
    memory_data = 16'h0000;
    chk({name, " mem_valid exec"}, 32'(memory_valid), 32'd0);
    chk({name, " accepts"}, 32'(accepts), 32'(v.acc));
    tick();
    n = 0; hold = 0; done = 0; extra_acc = 0;
    seen_pc = '0; seen_cc = 1'b0;
    got_pc[0] = '0; got_pc[1] = '0; got_cc[0] = 1'b0; got_cc[1] = 1'b0;
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      if (accepts) extra_acc++;
      if (output_pc_valid) begin
        if (!hold) begin
          seen_pc = output_pc;
          seen_cc = output_cc_id;
          hold = 1;
          output_pc_ready = 1'b0;
        end else begin
          chk({name, " out stable pc"}, 32'(output_pc), 32'(seen_pc));
          chk({name, " out stable cc"}, 32'(output_cc_id), 32'(seen_cc));
          if (n < 2) begin
            got_pc[n] = output_pc;
            got_cc[n] = output_cc_id;
          end
          n++;
          hold = 0;
          output_pc_ready = 1'b1;
        end
        tick();
        output_pc_ready = 1'b0;
      end else if (input_pc_ready) begin
        done = 1;
      end else begin
        tick();
      end
    end
    chk({name, " back to idle"}, 32'(done), 32'd1);
    chk({name, " n outputs"}, 32'(n), 32'(v.nout));
    chk({name, " stray accepts"}, 32'(extra_acc), 32'd0);
    if (v.nout > 0) begin
      chk({name, " out0 pc"}, 32'(got_pc[0]), 32'(v.p0));
      chk({name, " out0 cc"}, 32'(got_cc[0]), 32'(v.c0));
    end
    if (v.nout > 1) begin
      chk({name, " out1 pc"}, 32'(got_pc[1]), 32'(v.p1));
      chk({name, " out1 cc"}, 32'(got_cc[1]), 32'(v.c1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ev;
    int nma;
    //         pc     cc    instr     chars     n  p0     c0    p1     c1    acc
    vec[0]  = '{8'd3,  1'b0, 16'h4061, 16'h0061, 1, 8'd4,  1'b1, 8'd0,  1'b0, 1'b0}; // MATCH 'a' hit
    vec[1]  = '{8'd3,  1'b0, 16'h4061, 16'h0062, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0}; // MATCH 'a' vs 'b'
    vec[2]  = '{8'd7,  1'b0, 16'h2020, 16'h0061, 2, 8'd8,  1'b0, 8'h20, 1'b0, 1'b0}; // SPLIT 0x20
    vec[3]  = '{8'd1,  1'b0, 16'h0000, 16'h4100, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b1}; // ACCEPT c==0
    vec[4]  = '{8'd1,  1'b0, 16'h0000, 16'h0078, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0}; // ACCEPT 'x'
    vec[5]  = '{8'd2,  1'b0, 16'hC000, 16'h0078, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b1}; // ACCEPT_PARTIAL
    vec[6]  = '{8'd9,  1'b1, 16'h6055, 16'h0000, 1, 8'h55, 1'b1, 8'd0,  1'b0, 1'b0}; // JMP
    vec[7]  = '{8'hFF, 1'b1, 16'hE061, 16'h6200, 1, 8'h00, 1'b0, 8'd0,  1'b0, 1'b0}; // NOT_MATCH, wraps
    vec[8]  = '{8'd4,  1'b1, 16'hE061, 16'h6100, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0}; // NOT_MATCH equal
    vec[9]  = '{8'hFF, 1'b1, 16'h407A, 16'h7A00, 1, 8'h00, 1'b0, 8'd0,  1'b0, 1'b0}; // MATCH cc1, wraps
`ifdef REGEX_CPU_MATCH_ANY_EN
    nma = 1;
`else
    nma = 0;
`endif
    vec[10] = '{8'd4,  1'b0, 16'hA000, 16'h0041, nma, 8'd5, 1'b1, 8'd0, 1'b0, 1'b0}; // MATCH_ANY 'A'
    vec[11] = '{8'd4,  1'b0, 16'hA000, 16'h4100, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0}; // MATCH_ANY c==0
    vec[12] = '{8'd6,  1'b0, 16'h9FFF, 16'h0041, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0}; // END, payload set
    vec[13] = '{8'h10, 1'b1, 16'h3FFF, 16'h0000, 2, 8'h11, 1'b1, 8'hFF, 1'b1, 1'b0}; // SPLIT wide data
    vec[14] = '{8'd0,  1'b0, 16'h5F61, 16'h0061, 1, 8'd1,  1'b1, 8'd0,  1'b0, 1'b0}; // MATCH upper bits
    vec[15] = '{8'd0,  1'b1, 16'h4061, 16'h0061, 0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0}; // MATCH picks char1

    rst = 1'b0;
    current_characters = '0;
    input_pc_valid = 1'b0;
    input_cc_id = '0;
    input_pc = '0;
    memory_ready = 1'b0;
    memory_data = '0;
    output_pc_ready = 1'b0;

    // Reset state
    #12;
    chk("reset in_ready", 32'(input_pc_ready), 32'd1);
    chk("reset mem_valid", 32'(memory_valid), 32'd0);
    chk("reset out_valid", 32'(output_pc_valid), 32'd0);
    chk("reset accepts", 32'(accepts), 32'd0);
    chk("reset mem_addr", 32'(memory_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      run_vec(vec[i], $sformatf("vec%0d", i));
    end

    // END_WITHOUT_ACCEPTING sweep over pc 0..127 with chars 0..63
    for (int p = 0; p < 128; p++) begin
      ev = '{8'(p), 1'(p >> 6), 16'h8000 | 16'(p * 37), {8'(p % 64), 8'((p + 11) % 64)},
             0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
      run_vec(ev, $sformatf("end_pc%0d", p));
    end

    // Asynchronous reset in the middle of a fetch
    nvec++;
    input_pc = 8'd5;
    input_cc_id = 1'b1;
    input_pc_valid = 1'b1;
    tick();
    input_pc_valid = 1'b0;
    chk("rstfetch mem_valid before", 32'(memory_valid), 32'd1);
    chk("rstfetch mem_addr before", 32'(memory_addr), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("rstfetch in_ready", 32'(input_pc_ready), 32'd1);
    chk("rstfetch mem_valid", 32'(memory_valid), 32'd0);
    chk("rstfetch out_valid", 32'(output_pc_valid), 32'd0);
    chk("rstfetch accepts", 32'(accepts), 32'd0);
    chk("rstfetch mem_addr", 32'(memory_addr), 32'd0);
    memory_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    memory_ready = 1'b0;
    chk("rstfetch idle after", 32'(input_pc_ready), 32'd1);
    chk("rstfetch no fetch after", 32'(memory_valid), 32'd0);
    chk("rstfetch no output after", 32'(output_pc_valid), 32'd0);

    // Core still works after the abort
    run_vec(vec[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
